sram_port_arbiter: RTL

Arbitrates the single-port RA1SHD SRAM macro between two requesters. Requester 0 is the SRAM_IO_CTRL serial loader. Requester 1 is the PSEUDO_SPT_INTF readout engine. It replaces the static is_intf_flag mux with a request/grant handshake, round-robin fairness, a guaranteed idle turnaround cycle between owners, and a hold watchdog. It sits between both controllers and the SRAM CEN/WEN/A/D pins; Q fans out directly to both requesters.

---
 rtl/sram_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port RA1SHD SRAM macro between two requesters:
//     requester 0 = SRAM_IO_CTRL serial loader (read/write)
//     requester 1 = PSEUDO_SPT_INTF readout engine (read-only)
//   Level request / registered grant, round-robin on ties, one forced idle
//   turnaround cycle between owners, and a sticky hold watchdog.
//
// Ports
//   CLK, rst_n          clock (rising edge), synchronous active-low reset
//   REQ0/CEN0/WEN0/A0/D0 requester 0 request and SRAM-side signals
//   REQ1/CEN1/WEN1/A1    requester 1 request and SRAM-side signals
//   CLR_TO              clears the sticky TIMEOUT flag
//   GNT0/GNT1           ownership indication, decoded from registered state
//   CEN/WEN/A/D         muxed SRAM pins (idle values when nobody owns)
//   BUSY                either grant active
//   TIMEOUT             sticky: an owner held the SRAM MAX_HOLD cycles while
//                       the other side was waiting
//
// Handshake: a requester raises REQx and holds it for its whole burst. The
// grant appears one cycle after REQx is first sampled high. CENx is ignored
// until GNTx is seen high. Dropping REQx releases the SRAM; ownership is
// never preempted.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8,
  parameter int MAX_HOLD   = 255
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  REQ0,
  input  logic                  CEN0,
  input  logic                  WEN0,
  input  logic [ADDR_WIDTH-1:0] A0,
  input  logic [DATA_WIDTH-1:0] D0,
  input  logic                  REQ1,
  input  logic                  CEN1,
  input  logic                  WEN1,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic                  CLR_TO,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  CEN,
  output logic                  WEN,
  output logic [ADDR_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] D,
  output logic                  BUSY,
  output logic                  TIMEOUT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  localparam logic [CNT_WIDTH-1:0] HOLD_MAX = CNT_WIDTH'(MAX_HOLD);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 r_last;      // last owner; 1 after reset so port 0 wins the first tie
  logic                 w_last_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_timeout;
  logic                 w_waiting;
  logic                 w_release;
  logic                 w_to_set;
  logic                 w_unused;

  // Requester 1 is read-only, so its WEN never reaches the SRAM.
  assign w_unused = WEN1;

  // Next-state logic. Leaving OWNx always goes through IDLE, which gives the
  // guaranteed one-cycle turnaround with CEN=1 before the next owner.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (REQ0 && REQ1) w_state_nxt = r_last ? S_OWN0 : S_OWN1;
        else if (REQ0)    w_state_nxt = S_OWN0;
        else if (REQ1)    w_state_nxt = S_OWN1;
      end
      S_OWN0: begin
        if (!REQ0) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = 1'b0;
        end
      end
      S_OWN1: begin
        if (!REQ1) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Watchdog: counts cycles the non-owner spends waiting on a held grant.
  assign w_waiting = ((r_state == S_OWN0) && REQ1) || ((r_state == S_OWN1) && REQ0);
  assign w_release = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_release || !w_waiting) w_cnt_nxt = '0;
    else if (r_cnt >= HOLD_MAX)  w_cnt_nxt = HOLD_MAX;
    else                         w_cnt_nxt = r_cnt + 1'b1;
  end

  // Re-asserted every cycle the counter sits at the limit, so a clear
  // request while the other side is still starved does not stick.
  assign w_to_set = w_waiting && !w_release && (w_cnt_nxt == HOLD_MAX);

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_to_set)    r_timeout <= 1'b1;
      else if (CLR_TO) r_timeout <= 1'b0;
    end
  end

  assign GNT0    = (r_state == S_OWN0);
  assign GNT1    = (r_state == S_OWN1);
  assign BUSY    = GNT0 || GNT1;
  assign TIMEOUT = r_timeout;

  // Pin mux driven from registered state only.
  always_comb begin
    CEN = 1'b1;
    WEN = 1'b1;
    A   = '0;
    D   = '0;
    case (r_state)
      S_OWN0: begin
        CEN = CEN0;
        WEN = WEN0;
        A   = A0;
        D   = D0;
      end
      S_OWN1: begin
        CEN = CEN1;
        WEN = 1'b1;
        A   = A1;
      end
      default: ;
    endcase
  end

endmodule
